// File: rtl/cpu.sv
// cpu: single-cycle RV32I integer core with private instruction memory,
// data memory and register file. One instruction retires per rising edge
// of clk. There is no external bus; programs and data are placed directly
// into instruction_memory.mem and data_memory.mem.
//
// Ports:
//   clk    system clock, all state commits on the rising edge
//   reset  asynchronous active-low reset; holds pc at 0 while low
//
// Parameters:
//   IMEM_DEPTH  instruction memory depth in 32-bit words
//   DMEM_DEPTH  data memory depth in 32-bit words (minimum 32)
//
// Build option:
//   SUBWORD_LSU_EN  adds LB/LH/LBU/LHU/SB/SH; without it those encodings
//                   retire as NOPs and LW/SW are unchanged.

module cpu_imem #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] addr,
  output logic [31:0]   rdata
);
  logic [31:0] mem [0:DEPTH-1];

  // Write port is reserved for a loader; the core ties it off.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[addr];
endmodule

module cpu_dmem #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = mem[addr];
endmodule

module cpu_regfile (
  input  logic        clk,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);
  logic [31:0] registers [0:31];

  always_ff @(posedge clk) begin
    if (we && (waddr != 5'd0)) registers[waddr] <= wdata;
  end

  assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : registers[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : registers[raddr2];
endmodule

module cpu #(
  parameter int IMEM_DEPTH = 64,
  parameter int DMEM_DEPTH = 64
) (
  input logic clk,
  input logic reset
);
  localparam int IAW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
  localparam int DAW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  logic [31:0]    pc, pc_plus4, next_pc, instr;
  logic [31:0]    imem_idx_full, dmem_idx_full;
  logic [IAW-1:0] imem_idx;
  logic [DAW-1:0] dmem_idx;

  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_data, rs2_data;
  logic [31:0] mem_addr, dmem_rdata;
  logic [31:0] load_data, store_wdata;
  logic [3:0]  store_be;
  logic        load_ok;
  logic        br_take, imm_ok, reg_ok;
  logic        rd_we;
  logic [31:0] rd_wdata;
  logic [3:0]  dmem_be;

  function automatic logic [31:0] alu_op(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] f3, input logic alt);
    logic [31:0] r;
    case (f3)
      3'b000:  r = alt ? (a - b) : (a + b);
      3'b001:  r = a << b[4:0];
      3'b010:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'b011:  r = (a < b) ? 32'd1 : 32'd0;
      3'b100:  r = a ^ b;
      3'b101:  r = alt ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
      3'b110:  r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  // Word indices wrap modulo the memory depth; byte offsets are dropped.
  assign imem_idx_full = {2'b00, pc[31:2]} % 32'(IMEM_DEPTH);
  assign imem_idx      = imem_idx_full[IAW-1:0];

  cpu_imem #(.DEPTH(IMEM_DEPTH), .AW(IAW)) instruction_memory (
    .clk   (clk),
    .we    (1'b0),
    .waddr ('0),
    .wdata (32'd0),
    .addr  (imem_idx),
    .rdata (instr)
  );

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  cpu_regfile reg_file (
    .clk    (clk),
    .we     (rd_we & reset),
    .waddr  (rd),
    .wdata  (rd_wdata),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rs1_data),
    .rdata2 (rs2_data)
  );

  assign mem_addr      = rs1_data + ((opcode == OP_STORE) ? imm_s : imm_i);
  assign dmem_idx_full = {2'b00, mem_addr[31:2]} % 32'(DMEM_DEPTH);
  assign dmem_idx      = dmem_idx_full[DAW-1:0];

  cpu_dmem #(.DEPTH(DMEM_DEPTH), .AW(DAW)) data_memory (
    .clk   (clk),
    .be    (dmem_be),
    .addr  (dmem_idx),
    .wdata (store_wdata),
    .rdata (dmem_rdata)
  );

`ifdef SUBWORD_LSU_EN
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  always_comb begin
    case (mem_addr[1:0])
      2'd0:    lane_byte = dmem_rdata[7:0];
      2'd1:    lane_byte = dmem_rdata[15:8];
      2'd2:    lane_byte = dmem_rdata[23:16];
      default: lane_byte = dmem_rdata[31:24];
    endcase
    // A misaligned halfword simply takes the lane picked by addr[1].
    lane_half = mem_addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
  end

  always_comb begin
    load_ok     = 1'b1;
    load_data   = dmem_rdata;
    store_be    = 4'h0;
    store_wdata = rs2_data;
    case (funct3)
      3'b000:  load_data = {{24{lane_byte[7]}}, lane_byte};
      3'b001:  load_data = {{16{lane_half[15]}}, lane_half};
      3'b010:  load_data = dmem_rdata;
      3'b100:  load_data = {24'd0, lane_byte};
      3'b101:  load_data = {16'd0, lane_half};
      default: load_ok   = 1'b0;
    endcase
    case (funct3)
      3'b000: begin
        store_be    = 4'b0001 << mem_addr[1:0];
        store_wdata = {4{rs2_data[7:0]}};
      end
      3'b001: begin
        store_be    = mem_addr[1] ? 4'b1100 : 4'b0011;
        store_wdata = {2{rs2_data[15:0]}};
      end
      3'b010:  store_be = 4'hF;
      default: store_be = 4'h0;
    endcase
  end
`else
  always_comb begin
    load_ok     = (funct3 == 3'b010);
    load_data   = dmem_rdata;
    store_be    = (funct3 == 3'b010) ? 4'hF : 4'h0;
    store_wdata = rs2_data;
  end
`endif

  always_comb begin
    case (funct3)
      3'b000:  br_take = (rs1_data == rs2_data);
      3'b001:  br_take = (rs1_data != rs2_data);
      3'b100:  br_take = ($signed(rs1_data) <  $signed(rs2_data));
      3'b101:  br_take = ($signed(rs1_data) >= $signed(rs2_data));
      3'b110:  br_take = (rs1_data <  rs2_data);
      3'b111:  br_take = (rs1_data >= rs2_data);
      default: br_take = 1'b0;
    endcase
  end

  // Encodings with unexpected funct7 bits are not RV32I and retire as NOPs.
  assign imm_ok = (funct3 == 3'b001) ? (funct7 == 7'h00) :
                  (funct3 == 3'b101) ? ((funct7 == 7'h00) || (funct7 == 7'h20)) : 1'b1;
  assign reg_ok = (funct7 == 7'h00) ||
                  ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101)));

  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    next_pc  = pc_plus4;
    rd_we    = 1'b0;
    rd_wdata = 32'd0;
    dmem_be  = 4'h0;
    case (opcode)
      OP_LUI: begin
        rd_we    = 1'b1;
        rd_wdata = imm_u;
      end
      OP_AUIPC: begin
        rd_we    = 1'b1;
        rd_wdata = pc + imm_u;
      end
      OP_JAL: begin
        rd_we    = 1'b1;
        rd_wdata = pc_plus4;
        next_pc  = pc + imm_j;
      end
      OP_JALR: begin
        // Target uses rs1 as read this cycle, so rd == rs1 is safe.
        if (funct3 == 3'b000) begin
          rd_we    = 1'b1;
          rd_wdata = pc_plus4;
          next_pc  = (rs1_data + imm_i) & ~32'd1;
        end
      end
      OP_BRANCH: begin
        if (br_take) next_pc = pc + imm_b;
      end
      OP_LOAD: begin
        rd_we    = load_ok;
        rd_wdata = load_data;
      end
      OP_STORE: begin
        dmem_be = store_be & {4{reset}};
      end
      OP_IMM: begin
        rd_we    = imm_ok;
        rd_wdata = alu_op(rs1_data, imm_i, funct3, (funct3 == 3'b101) & instr[30]);
      end
      OP_REG: begin
        rd_we    = reg_ok;
        rd_wdata = alu_op(rs1_data, rs2_data, funct3, instr[30]);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc <= 32'd0;
    else        pc <= next_pc;
  end

  logic unused_bits;
  assign unused_bits = ^{pc[1:0], mem_addr[1:0],
                         imem_idx_full[31:IAW], dmem_idx_full[31:DAW]};
endmodule

// File: tb/tb_cpu.sv
module tb_cpu;
  logic clk;
  logic reset;

  cpu dut (
    .clk   (clk),
    .reset (reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;   // edge count after reset release; -1 = async check
    int          kind;  // 0 register, 1 data memory word, 2 pc
    int          idx;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   edge_cnt = 0;
  logic async_req = 1'b0;

  always @(posedge clk) begin
    if (reset) edge_cnt <= edge_cnt + 1;
    else       edge_cnt <= 0;
  end

  function automatic logic [31:0] actual_of(input exp_t e);
    case (e.kind)
      0:       return dut.reg_file.registers[e.idx];
      1:       return dut.data_memory.mem[e.idx];
      default: return dut.pc;
    endcase
  endfunction

  function automatic bit ready(input exp_t e);
    if (async_req) return (e.cyc == -1);
    return (e.cyc > 0) && (e.cyc <= edge_cnt);
  endfunction

  // Monitor: retires expectations as the DUT reaches them.
  always begin
    @(negedge clk or posedge async_req);
    while (sb.size() > 0 && ready(sb[0])) begin
      exp_t        e;
      logic [31:0] act;
      e   = sb.pop_front();
      act = actual_of(e);
      checks++;
      if (act !== e.val) begin
        failures++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.val);
      end
    end
  end

  task automatic exp_reg(input int cyc, input int r, input logic [31:0] v, input string nm);
    sb.push_back('{cyc, 0, r, v, nm});
  endtask
  task automatic exp_mem(input int cyc, input int i, input logic [31:0] v, input string nm);
    sb.push_back('{cyc, 1, i, v, nm});
  endtask
  task automatic exp_pc(input int cyc, input logic [31:0] v, input string nm);
    sb.push_back('{cyc, 2, 0, v, nm});
  endtask

  function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm[11:0], rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [31:0] imm);
    return enc_i(imm, rs1, 3'b000, rd, 7'h13);
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
  endfunction

  logic [31:0] prog[$];

  // Holds the core in reset and loads prog into a NOP-filled imem.
  task automatic begin_run();
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 64; i++) dut.instruction_memory.mem[i] = 32'h0000_0013;
    foreach (prog[i]) dut.instruction_memory.mem[i] = prog[i];
    dut.reg_file.registers[0] = 32'd0;
  endtask

  task automatic build_prog_a();
    prog = {};
    prog.push_back(enc_i(0, 0, 3'b010, 1, 7'h03));          // 00 LW x1,0(x0)
    prog.push_back(enc_s(4, 1, 0, 3'b010));                 // 04 SW x1,4(x0)
    prog.push_back(addi(1, 0, 15));                         // 08
    prog.push_back(addi(2, 0, 5));                          // 0C
    prog.push_back(enc_r(7'h00, 2, 1, 3'b000, 3));          // 10 ADD
    prog.push_back(enc_r(7'h20, 2, 1, 3'b000, 4));          // 14 SUB
    prog.push_back(enc_r(7'h00, 2, 1, 3'b111, 5));          // 18 AND
    prog.push_back(enc_r(7'h00, 2, 1, 3'b110, 6));          // 1C OR
    prog.push_back(enc_r(7'h00, 1, 2, 3'b010, 8));          // 20 SLT x8,x2,x1
    prog.push_back(addi(9, 0, 1));                          // 24
    prog.push_back(addi(10, 9, 32'hFFFF_FFFF));             // 28
    prog.push_back(addi(11, 0, 2047));                      // 2C
    prog.push_back(addi(12, 0, 32'hFFFF_F800));             // 30
    prog.push_back(addi(0, 0, 32'hFFFF_FFFF));              // 34
    prog.push_back(addi(13, 0, 124));                       // 38
    prog.push_back(enc_s(0, 2, 13, 3'b010));                // 3C SW x2,0(x13)
    prog.push_back(enc_i(40, 0, 3'b010, 28, 7'h03));        // 40 LW x28,40(x0)
    prog.push_back(addi(29, 28, 1));                        // 44
    prog.push_back(enc_r(7'h20, 1, 0, 3'b000, 15));         // 48 SUB x15,x0,x1
    prog.push_back(enc_r(7'h20, 2, 15, 3'b101, 16));        // 4C SRA
    prog.push_back(enc_r(7'h00, 2, 15, 3'b101, 17));        // 50 SRL
    prog.push_back(enc_r(7'h00, 15, 1, 3'b011, 18));        // 54 SLTU
    prog.push_back(enc_r(7'h00, 15, 1, 3'b010, 19));        // 58 SLT
    prog.push_back(enc_r(7'h00, 2, 1, 3'b100, 20));         // 5C XOR
    prog.push_back(enc_r(7'h00, 2, 2, 3'b001, 21));         // 60 SLL
    prog.push_back({20'h12345, 5'd22, 7'h37});              // 64 LUI
    prog.push_back({20'h00001, 5'd23, 7'h17});              // 68 AUIPC
    prog.push_back(32'h0000_0F0F);                          // 6C FENCE, rd field x30
    prog.push_back(addi(24, 0, 7));                         // 70
    prog.push_back(enc_i(3, 0, 3'b000, 25, 7'h03));         // 74 LB x25,3(x0)
  endtask

  task automatic preload_a();
    dut.data_memory.mem[0]  = 32'hDEAD_BEEF;
    dut.data_memory.mem[1]  = 32'd0;
    dut.data_memory.mem[10] = 32'h0000_00FF;
    dut.data_memory.mem[31] = 32'd0;
    dut.reg_file.registers[30] = 32'h55;
    dut.reg_file.registers[25] = 32'h77;
  endtask

  initial begin
    reset = 1'b0;

    // Run A: load/store, ALU, immediates, boundaries, NOP opcodes.
    build_prog_a();
    begin_run();
    preload_a();
    exp_pc(1, 32'h4, "pc_after_first");
    exp_reg(1, 1, 32'hDEAD_BEEF, "lw_x1");
    exp_mem(2, 1, 32'hDEAD_BEEF, "sw_mem1");
    exp_reg(5, 3, 32'h14, "add");
    exp_reg(6, 4, 32'hA, "sub");
    exp_reg(7, 5, 32'h5, "and");
    exp_reg(8, 6, 32'hF, "or");
    exp_reg(9, 8, 32'h1, "slt_x8");
    exp_reg(10, 9, 32'h1, "addi_x9");
    exp_reg(11, 10, 32'h0, "addi_neg1");
    exp_reg(12, 11, 32'h7FF, "addi_2047");
    exp_reg(13, 12, 32'hFFFF_F800, "addi_m2048");
    exp_reg(14, 0, 32'h0, "x0_const");
    exp_mem(16, 31, 32'h5, "sw_addr124");
    exp_reg(17, 28, 32'hFF, "lw_x28");
    exp_reg(18, 29, 32'h100, "load_use");
    exp_reg(19, 15, 32'hFFFF_FFF1, "sub_neg");
    exp_reg(20, 16, 32'hFFFF_FFFF, "sra");
    exp_reg(21, 17, 32'h07FF_FFFF, "srl");
    exp_reg(22, 18, 32'h1, "sltu");
    exp_reg(23, 19, 32'h0, "slt_signed");
    exp_reg(24, 20, 32'hA, "xor");
    exp_reg(25, 21, 32'hA0, "sll");
    exp_reg(26, 22, 32'h1234_5000, "lui");
    exp_reg(27, 23, 32'h0000_1068, "auipc");
    exp_reg(28, 30, 32'h55, "fence_nop");
    exp_reg(29, 24, 32'h7, "after_nop");
`ifdef SUBWORD_LSU_EN
    exp_reg(30, 25, 32'hFFFF_FFDE, "lb");
`else
    exp_reg(30, 25, 32'h77, "lb_nop");
`endif
    exp_pc(30, 32'h78, "pc_end_a");
    @(negedge clk) reset = 1'b1;
    repeat (30) @(negedge clk);

    checks++;
    if (dut.data_memory.mem[31] !== 32'h5) begin
      failures++;
      $display("FAIL direct_mem31: got %h expected %h", dut.data_memory.mem[31], 32'h5);
    end
    checks++;
    if (dut.reg_file.registers[29] !== 32'h100) begin
      failures++;
      $display("FAIL direct_x29: got %h expected %h", dut.reg_file.registers[29], 32'h100);
    end

    // Run B: branches and jumps at fixed addresses.
    prog = {};
    prog.push_back(addi(1, 0, 3));                            // 00
    prog.push_back(addi(2, 0, 3));                            // 04
    repeat (5) prog.push_back(32'h0000_0013);                 // 08..18
    prog.push_back(enc_b(8, 2, 1, 3'b000));                   // 1C BEQ +8
    prog.push_back(addi(15, 0, 9));                           // 20 skipped
    prog.push_back(addi(14, 0, 2));                           // 24
    prog.push_back(enc_b(8, 2, 1, 3'b001));                   // 28 BNE not taken
    prog.push_back(addi(16, 0, 5));                           // 2C
    prog.push_back(enc_j(8, 18));                             // 30 JAL x18,+8
    prog.push_back(addi(19, 0, 1));                           // 34 skipped
    prog.push_back(addi(21, 0, 32'h40));                      // 38
    prog.push_back(enc_i(4, 21, 3'b000, 22, 7'h67));          // 3C JALR x22,4(x21)
    prog.push_back(addi(23, 0, 1));                           // 40 skipped
    prog.push_back(enc_b(8, 1, 24, 3'b100));                  // 44 BLT taken
    prog.push_back(32'h0000_0013);                            // 48
    prog.push_back(enc_b(8, 1, 24, 3'b110));                  // 4C BLTU not taken
    prog.push_back(enc_b(32'hFFFF_FFB0, 24, 1, 3'b101));      // 50 BGE to 0
    begin_run();
    dut.reg_file.registers[15] = 32'd0;
    dut.reg_file.registers[19] = 32'd0;
    dut.reg_file.registers[23] = 32'd0;
    dut.reg_file.registers[24] = 32'hFFFF_FFFF;
    exp_pc(8, 32'h24, "beq_taken");
    exp_reg(9, 14, 32'h2, "beq_target");
    exp_pc(10, 32'h2C, "bne_not_taken");
    exp_reg(11, 16, 32'h5, "bne_fallthru");
    exp_reg(12, 18, 32'h34, "jal_link");
    exp_pc(12, 32'h38, "jal_target");
    exp_reg(14, 22, 32'h40, "jalr_link");
    exp_pc(14, 32'h44, "jalr_target");
    exp_pc(15, 32'h4C, "blt_taken");
    exp_pc(16, 32'h50, "bltu_not_taken");
    exp_pc(17, 32'h0, "bge_back");
    exp_reg(17, 15, 32'h0, "skip_beq");
    exp_reg(17, 19, 32'h0, "skip_jal");
    exp_reg(17, 23, 32'h0, "skip_jalr");
    @(negedge clk) reset = 1'b1;
    repeat (17) @(negedge clk);

    // Run C: asynchronous reset mid-program, then restart from 0.
    build_prog_a();
    begin_run();
    preload_a();
    @(negedge clk) reset = 1'b1;
    repeat (6) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (dut.pc !== 32'h0) begin
      failures++;
      $display("FAIL direct_async_pc: got %h expected %h", dut.pc, 32'h0);
    end
    checks++;
    if (dut.reg_file.registers[3] !== 32'h14) begin
      failures++;
      $display("FAIL direct_async_x3: got %h expected %h", dut.reg_file.registers[3], 32'h14);
    end
    exp_pc(-1, 32'h0, "async_reset_pc");
    exp_reg(-1, 1, 32'hF, "async_keep_x1");
    exp_reg(-1, 3, 32'h14, "async_keep_x3");
    exp_reg(-1, 4, 32'hA, "async_keep_x4");
    async_req = 1'b1;
    #1 async_req = 1'b0;
    @(posedge clk);
    #1;
    exp_pc(-1, 32'h0, "reset_hold_pc");
    async_req = 1'b1;
    #1 async_req = 1'b0;
    exp_reg(1, 1, 32'hDEAD_BEEF, "restart_lw");
    exp_pc(1, 32'h4, "restart_pc1");
    exp_pc(2, 32'h8, "restart_pc2");
    @(negedge clk) reset = 1'b1;
    repeat (3) @(negedge clk);

    #2;
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      failures++;
      $display("FAIL %s: never reached, expected %h", e.name, e.val);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
